// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity link: receiver FSM states, line
// levels and the parity helper that the transmit side also uses.
package serial_parity_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned STAT_W     = 16;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  // XOR reduction of a (zero-extended) word, inverted for odd parity.
  function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data,
                                       input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Word output channel of the serial parity receiver (valid/ready).
//   out_data    : assembled word, bit 0 = first data bit received
//   out_par_err : parity mismatch for out_data
//   out_frm_err : stop bit was sampled low for out_data
//   out_valid   : word available
//   out_ready   : consumer accepts when out_valid && out_ready
interface serial_parity_rx_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_par_err;
  logic              out_frm_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_par_err,
    output out_frm_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_par_err,
    input  out_frm_err,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/serial_parity_rx_stats.sv
// Saturating receive statistics for serial_parity_rx.
//   clk, reset       : clock, synchronous active-high reset
//   i_clear          : zeroes all counters
//   i_frame          : a stop bit was sampled
//   i_par_commit     : a word with a parity error was committed
//   i_drop           : a completed frame was dropped (overrun event)
//   o_frame_cnt, o_par_err_cnt, o_drop_cnt : counters, saturate at all-ones
module serial_parity_rx_stats
  import serial_parity_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_frame,
  input  logic              i_par_commit,
  input  logic              i_drop,
  output logic [STAT_W-1:0] o_frame_cnt,
  output logic [STAT_W-1:0] o_par_err_cnt,
  output logic [STAT_W-1:0] o_drop_cnt
);

  logic [STAT_W-1:0] r_frame_cnt;
  logic [STAT_W-1:0] r_par_err_cnt;
  logic [STAT_W-1:0] r_drop_cnt;

  // Counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_frame_cnt   <= '0;
      r_par_err_cnt <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (i_frame && !(&r_frame_cnt))
        r_frame_cnt <= r_frame_cnt + STAT_W'(1);
      if (i_par_commit && !(&r_par_err_cnt))
        r_par_err_cnt <= r_par_err_cnt + STAT_W'(1);
      if (i_drop && !(&r_drop_cnt))
        r_drop_cnt <= r_drop_cnt + STAT_W'(1);
    end
  end

  assign o_frame_cnt   = r_frame_cnt;
  assign o_par_err_cnt = r_par_err_cnt;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial parity receiver: assembles a start/data(LSB first)/parity/stop frame
// sampled on bit_en strobes, checks parity and framing, and presents the word
// on a valid/ready channel. A frame completing while the previous word is still
// pending is dropped and flags the sticky overrun.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bit_en     : one-cycle bit strobe; rx_bit sampled only when high
//   rx_bit     : serial line, idles high
//   clear      : clears overrun (and the statistics counters)
//   overrun    : sticky dropped-frame flag
//   out_if     : word output channel (master side)
// Optional: SERIAL_PARITY_RX_STATS_EN adds frame_cnt, par_err_cnt, drop_cnt.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_en,
  input  logic               rx_bit,
  input  logic               clear,
  output logic               overrun,
  serial_parity_rx_if.master out_if
`ifdef SERIAL_PARITY_RX_STATS_EN
  ,
  output logic [STAT_W-1:0]  frame_cnt,
  output logic [STAT_W-1:0]  par_err_cnt,
  output logic [STAT_W-1:0]  drop_cnt
`endif
);

  localparam int unsigned     CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic            PAR_SEL  = 1'(PARITY_ODD);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_start;
  logic              w_data_bit;
  logic              w_par_bit;
  logic              w_stop_bit;
  logic              w_commit;
  logic              w_drop;

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_xor;
  logic              r_par_err;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_par_err;
  logic              r_out_frm_err;
  logic              r_out_valid;
  logic              r_overrun;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-strobe datapath enables.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_data_bit  = 1'b0;
    w_par_bit   = 1'b0;
    w_stop_bit  = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (rx_bit == START_BIT) begin
            w_start     = 1'b1;
            w_state_nxt = DATA;
          end
        end
        DATA: begin
          w_data_bit = 1'b1;
          if (r_cnt == LAST_IDX) w_state_nxt = PARITY;
        end
        PARITY: begin
          w_par_bit   = 1'b1;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_stop_bit  = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    // A pending word that is being accepted this cycle frees the slot.
    w_commit = w_stop_bit & (~r_out_valid | out_if.out_ready);
    w_drop   = w_stop_bit & r_out_valid & ~out_if.out_ready;
  end

  // Frame assembly: shift register, bit counter and running parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_xor     <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
        r_xor <= 1'b0;
      end
      if (w_data_bit) begin
        r_shift[r_cnt] <= rx_bit;
        r_xor          <= r_xor ^ rx_bit;
        if (r_cnt != LAST_IDX) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_par_bit)
        r_par_err <= parity_calc(MAX_DATA_W'({r_xor, rx_bit}), PAR_SEL);
    end
  end

  // Output word register, handshake and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data    <= '0;
      r_out_par_err <= 1'b0;
      r_out_frm_err <= 1'b0;
      r_out_valid   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_commit) begin
        r_out_data    <= r_shift;
        r_out_par_err <= r_par_err;
        r_out_frm_err <= ~rx_bit;
        r_out_valid   <= 1'b1;
      end else if (r_out_valid && out_if.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop)     r_overrun <= 1'b1;
      else if (clear) r_overrun <= 1'b0;
    end
  end

  assign out_if.out_data    = r_out_data;
  assign out_if.out_par_err = r_out_par_err;
  assign out_if.out_frm_err = r_out_frm_err;
  assign out_if.out_valid   = r_out_valid;
  assign overrun            = r_overrun;

`ifdef SERIAL_PARITY_RX_STATS_EN
  logic w_par_commit;
  assign w_par_commit = w_commit & r_par_err;

  serial_parity_rx_stats u_stats (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (clear),
    .i_frame       (w_stop_bit),
    .i_par_commit  (w_par_commit),
    .i_drop        (w_drop),
    .o_frame_cnt   (frame_cnt),
    .o_par_err_cnt (par_err_cnt),
    .o_drop_cnt    (drop_cnt)
  );
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: an even-parity and an odd-parity instance share
// one stimulus stream; a frame-level model predicts the output channel.
module tb_serial_parity_rx;
  import serial_parity_pkg::*;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset     = 1'b1;
  logic bit_en    = 1'b0;
  logic rx_bit    = LINE_IDLE;
  logic clear     = 1'b0;
  logic out_ready = 1'b1;
  logic ovr_e, ovr_o;

  serial_parity_rx_if #(.DATA_W(DW)) if_e ();
  serial_parity_rx_if #(.DATA_W(DW)) if_o ();
  assign if_e.out_ready = out_ready;
  assign if_o.out_ready = out_ready;

`ifdef SERIAL_PARITY_RX_STATS_EN
  logic [15:0] fc_e, pc_e, dc_e, fc_o, pc_o, dc_o;
`endif

  serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(0)) u_dut_even (
    .clk     (clk),
    .reset   (reset),
    .bit_en  (bit_en),
    .rx_bit  (rx_bit),
    .clear   (clear),
    .overrun (ovr_e),
    .out_if  (if_e)
`ifdef SERIAL_PARITY_RX_STATS_EN
    ,
    .frame_cnt   (fc_e),
    .par_err_cnt (pc_e),
    .drop_cnt    (dc_e)
`endif
  );

  serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(1)) u_dut_odd (
    .clk     (clk),
    .reset   (reset),
    .bit_en  (bit_en),
    .rx_bit  (rx_bit),
    .clear   (clear),
    .overrun (ovr_o),
    .out_if  (if_o)
`ifdef SERIAL_PARITY_RX_STATS_EN
    ,
    .frame_cnt   (fc_o),
    .par_err_cnt (pc_o),
    .drop_cnt    (dc_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame-level model: the driver announces each completed frame on its stop strobe.
  logic        m_stop_now = 1'b0;
  logic [15:0] m_in_data  = '0;
  logic        m_in_par   = 1'b0;
  logic        m_in_stop  = 1'b1;

  logic        m_valid = 1'b0, m_ovr = 1'b0, m_frm = 1'b0;
  logic        m_perr_e = 1'b0, m_perr_o = 1'b0;
  logic [15:0] m_data = '0;
  int          m_fc = 0, m_pc_e = 0, m_pc_o = 0, m_dc = 0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(posedge clk) begin
    logic busy, pe;
    busy = m_valid && !out_ready;
    pe   = (^m_in_data) ^ m_in_par;
    if (reset) begin
      m_valid <= 1'b0; m_ovr <= 1'b0; m_frm <= 1'b0;
      m_perr_e <= 1'b0; m_perr_o <= 1'b0; m_data <= '0;
      m_fc <= 0; m_pc_e <= 0; m_pc_o <= 0; m_dc <= 0;
    end else begin
      if (m_stop_now && busy) begin
        m_ovr <= 1'b1;
      end else if (m_stop_now) begin
        m_valid  <= 1'b1;
        m_data   <= m_in_data;
        m_perr_e <= pe;
        m_perr_o <= ~pe;
        m_frm    <= ~m_in_stop;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      if (clear && !(m_stop_now && busy)) m_ovr <= 1'b0;
      if (clear) begin
        m_fc <= 0; m_pc_e <= 0; m_pc_o <= 0; m_dc <= 0;
      end else begin
        if (m_stop_now)                m_fc   <= sat_inc(m_fc);
        if (m_stop_now && busy)        m_dc   <= sat_inc(m_dc);
        if (m_stop_now && !busy && pe)  m_pc_e <= sat_inc(m_pc_e);
        if (m_stop_now && !busy && !pe) m_pc_o <= sat_inc(m_pc_o);
      end
    end
  end

  // Per-cycle comparison against the model.
  logic started = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      chk("valid_even", if_e.out_valid, m_valid);
      chk("valid_odd",  if_o.out_valid, m_valid);
      chk("ovr_even",   ovr_e, m_ovr);
      chk("ovr_odd",    ovr_o, m_ovr);
      if (m_valid) begin
        chk("data_even", if_e.out_data, m_data);
        chk("data_odd",  if_o.out_data, m_data);
        chk("perr_even", if_e.out_par_err, m_perr_e);
        chk("perr_odd",  if_o.out_par_err, m_perr_o);
        chk("frm_even",  if_e.out_frm_err, m_frm);
        chk("frm_odd",   if_o.out_frm_err, m_frm);
      end
`ifdef SERIAL_PARITY_RX_STATS_EN
      chk("fcnt_even", fc_e, 64'(m_fc));
      chk("fcnt_odd",  fc_o, 64'(m_fc));
      chk("pcnt_even", pc_e, 64'(m_pc_e));
      chk("pcnt_odd",  pc_o, 64'(m_pc_o));
      chk("dcnt_even", dc_e, 64'(m_dc));
      chk("dcnt_odd",  dc_o, 64'(m_dc));
`endif
    end
  end

  // One strobed bit followed by gap-1 unsampled cycles with a toggling line.
  task automatic drive_bit(input logic b, input int gap);
    bit_en = 1'b1;
    rx_bit = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
    for (int i = 1; i < gap; i++) begin
      rx_bit = ~rx_bit;
      @(posedge clk); #1;
    end
    rx_bit = LINE_IDLE;
  endtask

  task automatic send_frame(input logic [15:0] d, input logic par, input logic stp, input int gap);
    drive_bit(START_BIT, gap);
    for (int i = 0; i < 16; i++) drive_bit(d[i], gap);
    drive_bit(par, gap);
    m_in_data  = d;
    m_in_par   = par;
    m_in_stop  = stp;
    m_stop_now = 1'b1;
    bit_en     = 1'b1;
    rx_bit     = stp;
    @(posedge clk); #1;
    m_stop_now = 1'b0;
    bit_en     = 1'b0;
    for (int i = 1; i < gap; i++) begin
      rx_bit = ~rx_bit;
      @(posedge clk); #1;
    end
    rx_bit = LINE_IDLE;
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    align();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] partial;
    partial = 16'h0055;

    // Reset state.
    align();
    started = 1'b1;
    align();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data",  if_e.out_data, 16'h0000);
    chk("rst_valid", if_e.out_valid, 1'b0);
    chk("rst_perr",  if_e.out_par_err, 1'b0);
    chk("rst_frm",   if_e.out_frm_err, 1'b0);
    chk("rst_ovr",   ovr_e, 1'b0);
    align();

    // Clean even-parity frame, valid for exactly one cycle.
    send_frame(16'hA5C3, 1'b0, 1'b1, 1);
    @(negedge clk);
    chk("a5c3_valid",    if_e.out_valid, 1'b1);
    chk("a5c3_data",     if_e.out_data, 16'hA5C3);
    chk("a5c3_perr",     if_e.out_par_err, 1'b0);
    chk("a5c3_frm",      if_e.out_frm_err, 1'b0);
    chk("a5c3_perr_odd", if_o.out_par_err, 1'b1);
    @(negedge clk);
    chk("a5c3_valid_drop", if_e.out_valid, 1'b0);
    align();

    // Wrong parity bit for even, right for odd.
    send_frame(16'hA5C3, 1'b1, 1'b1, 1);
    @(negedge clk);
    chk("a5c3p1_data",     if_e.out_data, 16'hA5C3);
    chk("a5c3p1_perr",     if_e.out_par_err, 1'b1);
    chk("a5c3p1_perr_odd", if_o.out_par_err, 1'b0);
    align();

    // Framing error, then an immediate back-to-back frame.
    send_frame(16'h0001, 1'b1, 1'b0, 1);
    fork
      send_frame(16'h00F0, 1'b0, 1'b1, 1);
      begin
        @(negedge clk);
        chk("frm_data", if_e.out_data, 16'h0001);
        chk("frm_frm",  if_e.out_frm_err, 1'b1);
        chk("frm_perr", if_e.out_par_err, 1'b0);
      end
    join
    @(negedge clk);
    chk("next_valid", if_e.out_valid, 1'b1);
    chk("next_data",  if_e.out_data, 16'h00F0);
    chk("next_frm",   if_e.out_frm_err, 1'b0);
    align();

    // Overrun with consumer stalled, then clear.
    pulse_reset();
    out_ready = 1'b0;
    send_frame(16'h1234, 1'b1, 1'b1, 1);
    send_frame(16'hBEEF, 1'b1, 1'b1, 1);
    @(negedge clk);
    chk("ovr_data",  if_e.out_data, 16'h1234);
    chk("ovr_valid", if_e.out_valid, 1'b1);
    chk("ovr_flag",  ovr_e, 1'b1);
`ifdef SERIAL_PARITY_RX_STATS_EN
    chk("ovr_fcnt", fc_e, 16'd2);
    chk("ovr_dcnt", dc_e, 16'd1);
`endif
    align();
    clear = 1'b1;
    align();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_flag", ovr_e, 1'b0);
    chk("clr_data", if_e.out_data, 16'h1234);
    align();
    out_ready = 1'b1;
    align();

    // Sparse strobes with glitching line between them.
    out_ready = 1'b0;
    send_frame(16'h5A5A, 1'b0, 1'b1, 4);
    @(negedge clk);
    chk("sparse_data", if_e.out_data, 16'h5A5A);
    chk("sparse_perr", if_e.out_par_err, 1'b0);
    chk("sparse_frm",  if_e.out_frm_err, 1'b0);
    align();
    out_ready = 1'b1;
    align();

    // Reset mid-frame: partial frame must vanish.
    drive_bit(START_BIT, 1);
    for (int i = 0; i < 7; i++) drive_bit(partial[i], 1);
    pulse_reset();
    out_ready = 1'b0;
    send_frame(16'hFFFF, 1'b0, 1'b1, 1);
    @(negedge clk);
    chk("ffff_data",  if_e.out_data, 16'hFFFF);
    chk("ffff_perr",  if_e.out_par_err, 1'b0);
    chk("ffff_valid", if_e.out_valid, 1'b1);
    align();
    out_ready = 1'b1;
    repeat (3) align();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
